// File: rtl/dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram_bridge
// Brief    : MEM-stage to SRAM-like data bus bridge, one outstanding access.
// Revision : 1.0
// ============================================================================
module dmem_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_err,
    input  logic              flush,
    input  logic              other_stall,
    output logic              d_req,
    output logic              d_wr,
    output logic [1:0]        d_size,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    input  logic              d_addr_ok,
    input  logic              d_data_ok,
    input  logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              d_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              start;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    // Gated by resetn so the bus request drops the instant reset asserts.
    assign start = resetn & (state == S_IDLE) & mem_en & ~mem_addr_err & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = d_addr_ok ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                if (d_addr_ok) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (d_data_ok) begin
                    next_state = other_stall ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (!other_stall) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        d_req     = start | (state == S_ADDR);
        d_wr      = wr_q;
        d_size    = size_q;
        d_addr    = addr_q;
        d_wdata   = wdata_q;
        if (state == S_IDLE) begin
            d_wr    = |mem_wen;
            d_size  = mem_size;
            d_addr  = mem_addr;
            d_wdata = mem_wdata;
        end
        d_stall   = start | (state == S_ADDR) | ((state == S_DATA) & ~d_data_ok);
        mem_rdata = ((state == S_DATA) && d_data_ok) ? d_rdata : rdata_q;
    end

    // Holding registers keep the request stable while the slave withholds addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                wr_q    <= |mem_wen;
                size_q  <= mem_size;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if ((state == S_DATA) && d_data_ok) begin
                rdata_q <= d_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sram_bridge
// Brief    : Self-checking bench for dmem_sram_bridge with request/data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dmem_sram_bridge;

    logic        clk;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_err;
    logic        flush;
    logic        other_stall;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic [31:0] mem_rdata;
    logic        d_stall;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic        in_data;
    int          n_checks;
    int          n_fail;

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_err (mem_addr_err),
        .flush        (flush),
        .other_stall  (other_stall),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_size       (d_size),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_addr_ok    (d_addr_ok),
        .d_data_ok    (d_data_ok),
        .d_rdata      (d_rdata),
        .mem_rdata    (mem_rdata),
        .d_stall      (d_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic stall);
        check({tag, "_req"}, {31'd0, d_req}, {31'd0, req});
        check({tag, "_stall"}, {31'd0, d_stall}, {31'd0, stall});
    endtask

    // Scoreboard monitor: address handshakes and read-data returns.
    always @(negedge clk) begin
        if (!resetn) begin
            in_data = 1'b0;
        end else begin
            if (in_data && d_data_ok) begin
                in_data = 1'b0;
                if (rd_q.size() == 0) begin
                    check("rdata_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sb_rdata", mem_rdata, rd_q.pop_front());
                end
            end
            if (d_req && d_addr_ok) begin
                in_data = 1'b1;
                if (req_q.size() == 0) begin
                    check("req_unexpected", 32'd1, 32'd0);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("sb_wr", {31'd0, d_wr}, {31'd0, e.wr});
                    check("sb_size", {30'd0, d_size}, {30'd0, e.size});
                    check("sb_addr", d_addr, e.addr);
                    check("sb_wdata", d_wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; in_data = 1'b0;
        resetn = 1'b0; mem_en = 1'b1; mem_wen = 4'd0; mem_size = 2'd2;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_addr_err = 1'b0; flush = 1'b0;
        other_stall = 1'b0; d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = 32'h0;

        // Reset state, with a pending load on the inputs
        @(negedge clk);
        chk_ctl("reset", 1'b0, 1'b0);
        check("reset_rdata", mem_rdata, 32'h0);
        next_cycle();
        resetn = 1'b1; mem_en = 1'b0;
        @(negedge clk);
        chk_ctl("idle", 1'b0, 1'b0);

        // Word load, best case
        next_cycle();
        mem_en = 1'b1; mem_wen = 4'd0; mem_size = 2'd2; mem_addr = 32'h1000; d_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h1000, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk_ctl("lw_c0", 1'b1, 1'b1);
        next_cycle();
        d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk_ctl("lw_c1", 1'b0, 1'b0);
        check("lw_bypass", mem_rdata, 32'hDEADBEEF);
        next_cycle();
        mem_en = 1'b0; d_data_ok = 1'b0; d_rdata = 32'h11111111;
        @(negedge clk);
        check("lw_held", mem_rdata, 32'hDEADBEEF);

        // Byte store, addr_ok in the fourth request cycle
        next_cycle();
        mem_en = 1'b1; mem_wen = 4'b0100; mem_size = 2'd0; mem_addr = 32'h2002;
        mem_wdata = 32'hABABABAB;
        push_req(1'b1, 2'd0, 32'h2002, 32'hABABABAB);
        for (int i = 0; i < 4; i++) begin
            d_addr_ok = (i == 3);
            @(negedge clk);
            chk_ctl($sformatf("sb_c%0d", i), 1'b1, 1'b1);
            check($sformatf("sb_addr_c%0d", i), d_addr, 32'h2002);
            check($sformatf("sb_size_c%0d", i), {30'd0, d_size}, 32'd0);
            check($sformatf("sb_wr_c%0d", i), {31'd0, d_wr}, 32'd1);
            next_cycle();
        end
        d_addr_ok = 1'b0;
        @(negedge clk);
        chk_ctl("sb_wait", 1'b0, 1'b1);
        next_cycle();
        d_data_ok = 1'b1; d_rdata = 32'h55AA55AA;
        rd_q.push_back(32'h55AA55AA);
        @(negedge clk);
        chk_ctl("sb_done", 1'b0, 1'b0);
        next_cycle();
        mem_en = 1'b0; d_data_ok = 1'b0; mem_wen = 4'd0; mem_wdata = 32'h0;

        // Load completing under other_stall, then HOLD for three cycles
        next_cycle();
        mem_en = 1'b1; mem_size = 2'd2; mem_addr = 32'h3000; d_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h3000, 32'h0);
        rd_q.push_back(32'hCAFEF00D);
        @(negedge clk);
        chk_ctl("hs_c0", 1'b1, 1'b1);
        next_cycle();
        d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hCAFEF00D; other_stall = 1'b1;
        @(negedge clk);
        chk_ctl("hs_c1", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            d_data_ok = (i == 1); d_addr_ok = 1'b1; d_rdata = 32'h99999999;
            @(negedge clk);
            chk_ctl($sformatf("hold_%0d", i), 1'b0, 1'b0);
            check($sformatf("hold_rdata_%0d", i), mem_rdata, 32'hCAFEF00D);
        end
        next_cycle();
        other_stall = 1'b0; d_data_ok = 1'b0; d_addr_ok = 1'b0;
        @(negedge clk);
        chk_ctl("hold_exit", 1'b0, 1'b0);
        check("hold_exit_rdata", mem_rdata, 32'hCAFEF00D);
        next_cycle();
        mem_addr = 32'h3004; d_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h3004, 32'h0);
        rd_q.push_back(32'h12345678);
        @(negedge clk);
        chk_ctl("hs_next", 1'b1, 1'b1);
        next_cycle();
        d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'h12345678;
        @(negedge clk);
        next_cycle();
        mem_en = 1'b0; d_data_ok = 1'b0;

        // Address error on lw at 0x1002
        next_cycle();
        mem_en = 1'b1; mem_addr = 32'h1002; mem_addr_err = 1'b1; d_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_ctl($sformatf("aerr_%0d", i), 1'b0, 1'b0);
            check($sformatf("aerr_rdata_%0d", i), mem_rdata, 32'h12345678);
            next_cycle();
        end
        mem_en = 1'b0; mem_addr_err = 1'b0; d_addr_ok = 1'b0;

        // Flush while in DATA
        next_cycle();
        mem_en = 1'b1; mem_addr = 32'h4000;
        @(negedge clk);
        chk_ctl("fl_c0", 1'b1, 1'b1);
        next_cycle();
        d_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h4000, 32'h0);
        @(negedge clk);
        chk_ctl("fl_c1", 1'b1, 1'b1);
        next_cycle();
        d_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk_ctl("fl_c2", 1'b0, 1'b1);
        next_cycle();
        d_data_ok = 1'b1; d_rdata = 32'h0BADF00D;
        rd_q.push_back(32'h0BADF00D);
        @(negedge clk);
        chk_ctl("fl_c3", 1'b0, 1'b0);
        next_cycle();
        d_data_ok = 1'b0;
        @(negedge clk);
        chk_ctl("fl_c4", 1'b0, 1'b0);
        next_cycle();
        flush = 1'b0; mem_en = 1'b0;

        // Reset pulse while in ADDR
        next_cycle();
        mem_en = 1'b1; mem_wen = 4'hF; mem_addr = 32'h5000; mem_wdata = 32'h77777777;
        @(negedge clk);
        chk_ctl("rs_c0", 1'b1, 1'b1);
        next_cycle();
        @(negedge clk);
        chk_ctl("rs_addr", 1'b1, 1'b1);
        next_cycle();
        resetn = 1'b0;
        #1;
        chk_ctl("rs_now", 1'b0, 1'b0);
        check("rs_now_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        next_cycle();
        resetn = 1'b1; mem_en = 1'b0; mem_wen = 4'd0;
        @(negedge clk);
        chk_ctl("rs_after", 1'b0, 1'b0);
        check("rs_after_rdata", mem_rdata, 32'h0);

        next_cycle();
        @(negedge clk);
        check("req_q_empty", req_q.size(), 32'd0);
        check("rd_q_empty", rd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
